// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10 over a valid/ready handshake,
// one shared byte-wide sbox for SubWord. Optional `AES_KEY_ZEROIZE_EN clears rk/tmp after key 10.

module sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        // NOTE: blocking assignments here are combinational temporaries, not state.
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;
    logic [7:0] sq;

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as required.
    always_comb begin
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
            {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EMIT = 2'd1;
    localparam logic [1:0] SUB  = 2'd2;
    localparam logic [1:0] MIX  = 2'd3;

    logic [1:0]  state;
    logic [31:0] tmp;
    logic [1:0]  bcnt;
    logic [7:0]  rcon;

    logic [31:0] rot;
    logic [7:0]  sbox_in;
    logic [7:0]  sbox_out;
    logic [31:0] t;
    logic [31:0] w4;
    logic [31:0] w5;
    logic [31:0] w6;
    logic [31:0] w7;

    assign rk_valid = (state == EMIT);
    assign busy     = (state != IDLE);

    assign rot = {rk[23:0], rk[31:24]};

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        sbox_in = rot[31:24];
        case (bcnt)
            2'd0: sbox_in = rot[31:24];
            2'd1: sbox_in = rot[23:16];
            2'd2: sbox_in = rot[15:8];
            2'd3: sbox_in = rot[7:0];
            default: sbox_in = rot[31:24];
        endcase
    end

    sbox u_sbox (
        .a (sbox_in),
        .s (sbox_out)
    );

    assign t  = tmp ^ {rcon, 24'h0};
    assign w4 = rk[127:96] ^ t;
    assign w5 = rk[95:64]  ^ w4;
    assign w6 = rk[63:32]  ^ w5;
    assign w7 = rk[31:0]   ^ w6;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rk     <= 128'h0;
            rk_idx <= 4'd0;
            done   <= 1'b0;
            tmp    <= 32'h0;
            bcnt   <= 2'd0;
            rcon   <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rk     <= key;
                        rk_idx <= 4'd0;
                        rcon   <= 8'h01;
                        state  <= EMIT;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (rk_idx == 4'd10) begin
                            state <= IDLE;
                            done  <= 1'b1;
`ifdef AES_KEY_ZEROIZE_EN
                            rk    <= 128'h0;
                            tmp   <= 32'h0;
`endif
                        end else begin
                            bcnt  <= 2'd0;
                            state <= SUB;
                        end
                    end
                end
                SUB: begin
                    case (bcnt)
                        2'd0: tmp[31:24] <= sbox_out;
                        2'd1: tmp[23:16] <= sbox_out;
                        2'd2: tmp[15:8]  <= sbox_out;
                        default: tmp[7:0] <= sbox_out;
                    endcase
                    bcnt <= bcnt + 2'd1;
                    if (bcnt == 2'd3) state <= MIX;
                end
                default: begin
                    rk     <= {w4, w5, w6, w7};
                    rk_idx <= rk_idx + 4'd1;
                    rcon   <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    state  <= EMIT;
                end
            endcase
        end
    end
endmodule
